// File: rtl/vga_sync_stage.sv
// vga_sync_stage
// Registered VGA timing decoder placed directly after the horizontal/vertical
// pixel counters. It turns the raw counts and their terminal flags into sync
// pulses, a video gate, visible-region coordinates, and frame bookkeeping. It
// tracks lock to the counter chain, and out-of-range counts force a relock.
//
// Ports
//   CLOCK       system clock (single domain)
//   Reset       synchronous, active-high reset
//   PixelTick   pixel enable; the upstream counters advance on the same edges
//   HCount      horizontal count (10 bits)
//   VCount      vertical count (10 bits)
//   HTerminal   last pixel of the line
//   VTerminal   last line of the frame
//   HSync       horizontal sync, active low
//   VSync       vertical sync, active low
//   VideoOn     visible pixel and stage locked (registered)
//   PixelX      HCount while visible, else 0
//   PixelY      VCount while visible, else 0
//   FrameTick   one-CLOCK pulse on each valid frame boundary
//   FrameCount  frames completed while locked, wraps at 8 bits
//   Locked      high while RUNNING
//   RangeError  sticky flag: a count reached or passed its total
module vga_sync_stage #(
  parameter int HVisible   = 640,
  parameter int HFront     = 16,
  parameter int HSyncWidth = 96,
  parameter int HBack      = 48,
  parameter int VVisible   = 480,
  parameter int VFront     = 10,
  parameter int VSyncWidth = 2,
  parameter int VBack      = 33
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic       PixelTick,
  input  logic [9:0] HCount,
  input  logic [9:0] VCount,
  input  logic       HTerminal,
  input  logic       VTerminal,
  output logic       HSync,
  output logic       VSync,
  output logic       VideoOn,
  output logic [9:0] PixelX,
  output logic [9:0] PixelY,
  output logic       FrameTick,
  output logic [7:0] FrameCount,
  output logic       Locked,
  output logic       RangeError
);

  // Every threshold is held in 11 bits so that the sums cannot wrap.
  localparam logic [10:0] HVis       = 11'(HVisible);
  localparam logic [10:0] HSyncStart = 11'(HVisible + HFront);
  localparam logic [10:0] HSyncEnd   = 11'(HVisible + HFront + HSyncWidth);
  localparam logic [10:0] HTotal     = 11'(HVisible + HFront + HSyncWidth + HBack);
  localparam logic [10:0] VVis       = 11'(VVisible);
  localparam logic [10:0] VSyncStart = 11'(VVisible + VFront);
  localparam logic [10:0] VSyncEnd   = 11'(VVisible + VFront + VSyncWidth);
  localparam logic [10:0] VTotal     = 11'(VVisible + VFront + VSyncWidth + VBack);

  typedef enum logic {
    SYNCING = 1'b0,
    RUNNING = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_q, video_d;
  logic [9:0] px_q, px_d;
  logic [9:0] py_q, py_d;
  logic       ftick_q, ftick_d;
  logic [7:0] fcount_q, fcount_d;
  logic       rerr_q, rerr_d;

  logic [10:0] h_ext, v_ext;
  logic        visible, hsync_win, vsync_win, bad, boundary;

  assign h_ext     = {1'b0, HCount};
  assign v_ext     = {1'b0, VCount};
  assign visible   = (h_ext < HVis) && (v_ext < VVis);
  assign hsync_win = (h_ext >= HSyncStart) && (h_ext < HSyncEnd);
  assign vsync_win = (v_ext >= VSyncStart) && (v_ext < VSyncEnd);
  assign bad       = (h_ext >= HTotal) || (v_ext >= VTotal);
  // A boundary that coincides with an out-of-range count does not count.
  assign boundary  = HTerminal && VTerminal && !bad;

  always_comb begin
    state_d  = state_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    video_d  = video_q;
    px_d     = px_q;
    py_d     = py_q;
    ftick_d  = 1'b0;
    fcount_d = fcount_q;
    rerr_d   = rerr_q;
    if (PixelTick) begin
      hsync_d = !hsync_win;
      vsync_d = !vsync_win;
      // Uses the present state, so the edge that enters RUNNING still blanks.
      video_d = visible && (state_q == RUNNING);
      px_d    = visible ? HCount : 10'd0;
      py_d    = visible ? VCount : 10'd0;
      ftick_d = boundary;
      if (boundary && (state_q == RUNNING)) begin
        fcount_d = fcount_q + 8'd1;
      end
      if (bad) begin
        rerr_d  = 1'b1;
        state_d = SYNCING;
      end else if (boundary) begin
        state_d = RUNNING;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state_q  <= SYNCING;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      video_q  <= 1'b0;
      px_q     <= 10'd0;
      py_q     <= 10'd0;
      ftick_q  <= 1'b0;
      fcount_q <= 8'd0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      video_q  <= video_d;
      px_q     <= px_d;
      py_q     <= py_d;
      ftick_q  <= ftick_d;
      fcount_q <= fcount_d;
      rerr_q   <= rerr_d;
    end
  end

  assign HSync      = hsync_q;
  assign VSync      = vsync_q;
  assign VideoOn    = video_q;
  assign PixelX     = px_q;
  assign PixelY     = py_q;
  assign FrameTick  = ftick_q;
  assign FrameCount = fcount_q;
  assign Locked     = (state_q == RUNNING);
  assign RangeError = rerr_q;

endmodule

// File: tb/tb_vga_sync_stage.sv
// Testbench for vga_sync_stage. It drives directed count sequences. A
// frame-level reference model predicts every output on every cycle, and
// hand-computed literal checks pin the model at the key points.
module tb_vga_sync_stage;

  localparam int HT = 800;
  localparam int VT = 525;

  logic       clk;
  logic       rst;
  logic       pt;
  logic [9:0] hc, vc;
  logic       hterm, vterm;
  logic       hsync, vsync, video_on, ftick, locked, rerr;
  logic [9:0] px, py;
  logic [7:0] fcount;

  int n_cmp;
  int n_bad;

  vga_sync_stage dut (
    .CLOCK(clk), .Reset(rst), .PixelTick(pt),
    .HCount(hc), .VCount(vc), .HTerminal(hterm), .VTerminal(vterm),
    .HSync(hsync), .VSync(vsync), .VideoOn(video_on),
    .PixelX(px), .PixelY(py), .FrameTick(ftick), .FrameCount(fcount),
    .Locked(locked), .RangeError(rerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: it computes what each registered output must read after
  // every edge, working directly from the line and frame rules.
  bit       model_valid;
  bit       m_run;
  bit       e_hsync, e_vsync, e_video, e_ftick, e_rerr;
  int       e_px, e_py, e_fc;

  always @(posedge clk) begin
    if (rst) begin
      model_valid = 1'b1;
      m_run = 0; e_hsync = 1; e_vsync = 1; e_video = 0; e_px = 0; e_py = 0;
      e_ftick = 0; e_fc = 0; e_rerr = 0;
    end else if (model_valid) begin
      if (pt) begin
        int h, v;
        bit vis, badc, bnd;
        h = int'(hc);
        v = int'(vc);
        vis  = (h < 640) && (v < 480);
        badc = (h >= HT) || (v >= VT);
        bnd  = hterm && vterm && !badc;
        e_hsync = !(h >= 656 && h <= 751);
        e_vsync = !(v == 490 || v == 491);
        e_video = vis && m_run;
        e_px    = vis ? h : 0;
        e_py    = vis ? v : 0;
        e_ftick = bnd;
        if (bnd && m_run) e_fc = (e_fc + 1) % 256;
        if (badc) e_rerr = 1;
        if (badc) m_run = 0;
        else if (bnd) m_run = 1;
      end else begin
        e_ftick = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("HSync", 32'(hsync), 32'(e_hsync));
      check("VSync", 32'(vsync), 32'(e_vsync));
      check("VideoOn", 32'(video_on), 32'(e_video));
      check("PixelX", 32'(px), 32'(e_px));
      check("PixelY", 32'(py), 32'(e_py));
      check("FrameTick", 32'(ftick), 32'(e_ftick));
      check("FrameCount", 32'(fcount), 32'(e_fc));
      check("Locked", 32'(locked), 32'(m_run));
      check("RangeError", 32'(rerr), 32'(e_rerr));
    end
  end

  // One CLOCK per call: inputs change on the falling edge, and the task
  // returns just after the rising edge that samples them.
  task automatic drive(input int h, input int v, input bit ht, input bit vt, input bit p);
    @(negedge clk);
    hc = 10'(h); vc = 10'(v); hterm = ht; vterm = vt; pt = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive($urandom_range(0, 1023), $urandom_range(0, 1023),
          1'($urandom), 1'($urandom), 1'b0);
  endtask

  function automatic bit sparse_px(input int h);
    return h == 0 || h == 1 || h == 10 || h == 639 || h == 640 || h == 641 ||
           h == 655 || h == 656 || h == 700 || h == 751 || h == 752 || h == 799;
  endfunction

  int hs_low, hs_first, hs_last, vs_lines, vs_first;

  // Walks one frame. Most lines visit only the interesting pixels. When
  // 'full' is set, lines 0 and 490 visit every pixel. 'half' inserts an idle
  // cycle with junk inputs after each active pixel.
  task automatic frame(input bit half, input bit full, input bit first);
    hs_low = 0; hs_first = -1; hs_last = -1; vs_lines = 0; vs_first = -1;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        bit whole;
        whole = full && (v == 0 || v == 490);
        if (!whole && !sparse_px(h)) continue;
        drive(h, v, h == HT - 1, v == VT - 1, 1'b1);
        if (full && v == 0 && !hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = h;
          hs_last = h;
        end
        if (h == 0 && !vsync) begin
          vs_lines++;
          if (vs_first < 0) vs_first = v;
        end
        if (full && h == 0 && v == 0) check("lit VideoOn(0,0)", 32'(video_on), 32'd1);
        if (full && h == 639 && v == 479) check("lit VideoOn(639,479)", 32'(video_on), 32'd1);
        if (full && h == 640 && v == 0) check("lit VideoOn(640,0)", 32'(video_on), 32'd0);
        if (first && h == 752 && v == VT - 1) check("lit Locked pre-boundary", 32'(locked), 32'd0);
        if (half) begin
          bit was_tick;
          was_tick = ftick;
          idle();
          if (was_tick) check("lit FrameTick width", 32'(ftick), 32'd0);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; model_valid = 0;
    rst = 1'b1; pt = 1'b0; hc = '0; vc = '0; hterm = 1'b0; vterm = 1'b0;

    for (int i = 0; i < 3; i++)
      drive($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom), 1'($urandom), 1'($urandom));
    check("lit rst HSync", 32'(hsync), 32'd1);
    check("lit rst VSync", 32'(vsync), 32'd1);
    check("lit rst VideoOn", 32'(video_on), 32'd0);
    check("lit rst PixelX", 32'(px), 32'd0);
    check("lit rst FrameCount", 32'(fcount), 32'd0);
    check("lit rst Locked", 32'(locked), 32'd0);
    check("lit rst RangeError", 32'(rerr), 32'd0);

    rst = 1'b0;
    drive(10, 10, 1'b0, 1'b0, 1'b1);
    check("lit syncing VideoOn", 32'(video_on), 32'd0);
    check("lit syncing PixelX", 32'(px), 32'd10);

    // The first frame acquires lock at its closing boundary.
    frame(1'b0, 1'b0, 1'b1);
    check("lit Locked after boundary", 32'(locked), 32'd1);
    check("lit FrameTick at lock", 32'(ftick), 32'd1);
    check("lit FrameCount at lock", 32'(fcount), 32'd0);

    // The second frame runs at half rate while locked.
    frame(1'b1, 1'b1, 1'b0);
    check("lit HSync low width", 32'(hs_low), 32'd96);
    check("lit HSync first low", 32'(hs_first), 32'd656);
    check("lit HSync last low", 32'(hs_last), 32'd751);
    check("lit VSync low lines", 32'(vs_lines), 32'd2);
    check("lit VSync first line", 32'(vs_first), 32'd490);
    check("lit FrameCount frame2", 32'(fcount), 32'd1);

    // An out-of-range HCount sets the sticky error and drops lock.
    drive(800, 100, 1'b0, 1'b0, 1'b1);
    check("lit RangeError H", 32'(rerr), 32'd1);
    check("lit Locked after bad", 32'(locked), 32'd0);
    drive(799, 524, 1'b1, 1'b1, 1'b1);
    check("lit relock", 32'(locked), 32'd1);
    check("lit RangeError sticky", 32'(rerr), 32'd1);
    check("lit FrameCount relock", 32'(fcount), 32'd1);

    // A boundary that coincides with a bad VCount must not count.
    drive(799, 600, 1'b1, 1'b1, 1'b1);
    check("lit bad bnd FrameTick", 32'(ftick), 32'd0);
    check("lit bad bnd FrameCount", 32'(fcount), 32'd1);
    check("lit bad bnd Locked", 32'(locked), 32'd0);
    drive(799, 524, 1'b1, 1'b1, 1'b1);

    // Wrap the frame counter: it starts at 1, reaches 255 after 254
    // boundaries, and then wraps to 0.
    for (int i = 1; i <= 256; i++) begin
      drive(0, 0, 1'b0, 1'b0, 1'b1);
      drive(799, 524, 1'b1, 1'b1, 1'b1);
      if (i == 254) check("lit FrameCount 255", 32'(fcount), 32'd255);
      if (i == 255) check("lit FrameCount wrap", 32'(fcount), 32'd0);
    end
    check("lit FrameCount after 256", 32'(fcount), 32'd1);

    // Assert reset in the middle of a line.
    drive(20, 30, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    drive(300, 100, 1'b0, 1'b0, 1'b1);
    check("lit midrst Locked", 32'(locked), 32'd0);
    check("lit midrst FrameCount", 32'(fcount), 32'd0);
    check("lit midrst PixelY", 32'(py), 32'd0);
    check("lit midrst RangeError", 32'(rerr), 32'd0);
    rst = 1'b0;
    drive(5, 5, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_stage.md
# vga_sync_stage

Registered VGA timing decoder that sits directly downstream of the Pong horizontal/vertical pixel counters. It consumes the two count values and their terminal-count flags and produces active-low HSync/VSync, a video-on gate, visible-region pixel coordinates, a per-frame tick and a frame counter. It tracks lock to the counter chain: video stays blanked until the first complete frame boundary. Out-of-range counts are flagged and force relock.

## Interface
Parameters:
- HVisible, 640, visible pixels per line
- HFront, 16, horizontal front porch
- HSyncWidth, 96, HSync pulse width
- HBack, 48, horizontal back porch (line total 800)
- VVisible, 480, visible lines per frame
- VFront, 10, vertical front porch
- VSyncWidth, 2, VSync pulse width
- VBack, 33, vertical back porch (frame total 525)

Ports:
- CLOCK  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- PixelTick  in  1  pixel clock enable; counters advance on the same edges
- HCount  in  10  horizontal counter value
- VCount  in  10  vertical counter value
- HTerminal  in  1  horizontal counter terminal count (last pixel of line)
- VTerminal  in  1  vertical counter terminal count (last line of frame)
- HSync  out  1  horizontal sync, active low
- VSync  out  1  vertical sync, active low
- VideoOn  out  1  high when the pixel is visible and the stage is locked
- PixelX  out  10  HCount while visible, else 0
- PixelY  out  10  VCount while visible, else 0
- FrameTick  out  1  one-CLOCK pulse at each valid frame boundary
- FrameCount  out  8  frames completed while locked, wraps 255->0
- Locked  out  1  high in RUNNING state
- RangeError  out  1  sticky: a count exceeded its total

## Operation
- Let HTotal = HVisible+HFront+HSyncWidth+HBack and VTotal likewise. All arithmetic is unsigned 10-bit; compare sums in 11 bits.
- Visible = (HCount < HVisible) && (VCount < VVisible).
- HSync low iff HVisible+HFront <= HCount < HVisible+HFront+HSyncWidth (656..751 by default). VSync low iff VVisible+VFront <= VCount < VVisible+VFront+VSyncWidth (490..491).
- Bad = (HCount >= HTotal) || (VCount >= VTotal). Boundary = HTerminal && VTerminal && !Bad.
- State machine, with all events qualified by PixelTick:
  - SYNCING (reset state): goes to RUNNING on Boundary.
  - RUNNING: goes to SYNCING on Bad; otherwise stays.
  - Bad in SYNCING stays SYNCING.
- Bad with PixelTick sets RangeError. Only Reset clears it.
- VideoOn = registered (Visible && state==RUNNING). The value is sampled before the edge, so the edge that enters RUNNING still gives VideoOn=0. HSync, VSync, PixelX and PixelY are generated in both states.
- FrameTick is asserted for one CLOCK on every Boundary edge, in either state. FrameCount increments on Boundary only when the state was already RUNNING.
- Simultaneous HTerminal/VTerminal with Bad: Bad wins. There is no FrameTick and no increment, and the state goes to SYNCING.

## Timing
- Reset, sampled at a CLOCK edge: HSync=1, VSync=1, VideoOn=0, PixelX=0, PixelY=0, FrameTick=0, FrameCount=0, Locked=0, RangeError=0, state SYNCING. Reset overrides PixelTick. Reset mid-frame gives those values on the next edge.
- Latency: all outputs are registered. They reflect the inputs sampled on the previous CLOCK edge where PixelTick=1, so there is exactly 1 CLOCK of delay.
- When PixelTick=0, every output holds, except FrameTick, which drops to 0 after one cycle.
- Locked rises on the edge that samples the first Boundary.

## Test plan
- Reset held 3 cycles with arbitrary inputs -> all outputs equal the reset values listed above. Then drive HCount=10, VCount=10 with PixelTick=1 -> VideoOn=0 (still SYNCING), PixelX=10.
- Sweep the counts 0..799 x 0..524 with correct terminals -> Locked rises after (799,524). On the second frame, VideoOn=1 at (0,0) and (639,479), and 0 at (640,0). HSync is low for exactly 96 pixels (656..751). VSync is low for lines 490..491. FrameCount=1 after the second boundary.
- PixelTick toggling 1-of-2 during the sweep -> outputs hold on idle cycles. FrameTick width is 1 CLOCK.
- While RUNNING, drive HCount=800 with PixelTick -> RangeError=1, Locked=0 next edge. It relocks at the next (799,524) boundary, and RangeError stays 1.
- HTerminal=VTerminal=1 with VCount=600 -> no FrameTick, FrameCount unchanged, RangeError=1.
- Run 256 locked frames -> FrameCount wraps from 255 to 0. Assert Reset mid-line -> all outputs return to reset values on the next edge.
